// File: rtl/counter_pkg.sv
// Shared constants and direction encoding for the cascaded modulo up/down counter.
package counter_pkg;

    localparam int DIGIT_W    = 4;
    localparam int MOD_MIN    = 2;
    localparam int MOD_MAX    = 16;
    localparam int DIGITS_MIN = 1;
    localparam int DIGITS_MAX = 8;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Out-of-range load nibbles saturate to the top legal digit value.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] nib,
                                                      input int mod);
        if (int'(nib) >= mod)
            return DIGIT_W'(mod - 1);
        return nib;
    endfunction

endpackage

// File: rtl/mod_digit_cell.sv
// One modulo-MOD digit: value register, wrap-around step, clamped load, and
// terminal flags used by the top level to build the cascade enables.
module mod_digit_cell
    import counter_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  dir_e               i_dir,
    input  logic [DIGIT_W-1:0] i_load_nib,
    output logic [DIGIT_W-1:0] o_value,
    output logic               o_at_max,
    output logic               o_at_zero
);

    localparam logic [DIGIT_W-1:0] MAX_V = DIGIT_W'(MOD - 1);

    logic [DIGIT_W-1:0] r_value;
    logic [DIGIT_W-1:0] w_next;

    assign o_at_max  = (r_value == MAX_V);
    assign o_at_zero = (r_value == '0);
    assign o_value   = r_value;

    always_comb begin
        w_next = r_value;
        if (i_dir == DIR_UP)
            w_next = o_at_max ? '0 : r_value + 1'b1;
        else
            w_next = o_at_zero ? MAX_V : r_value - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_value <= '0;
        else if (i_load)
            r_value <= clamp_digit(i_load_nib, MOD);
        else if (i_step)
            r_value <= w_next;
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Cascaded DIGITS x modulo-MOD up/down counter with parallel load, combinational
// terminal-count flag and a registered wrap/saturate pulse.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int DIGITS = 2,
    parameter int MOD    = 10,
    parameter int WRAP   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sta,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   num,
    output logic                  cop,
    output logic                  ovf
);

    if (MOD < MOD_MIN || MOD > MOD_MAX) begin : g_bad_mod
        $error("mod_updown_counter: MOD must be in 2..16");
    end
    if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
        $error("mod_updown_counter: DIGITS must be in 1..8");
    end

    dir_e              w_dir;
    logic [DIGITS:0]   w_lo_max;
    logic [DIGITS:0]   w_lo_zero;
    logic [DIGITS-1:0] w_at_max;
    logic [DIGITS-1:0] w_at_zero;
    logic              w_cnt;
    logic              r_ovf;

    assign w_dir        = dir_e'(sta);
    assign w_lo_max[0]  = 1'b1;
    assign w_lo_zero[0] = 1'b1;

    // In saturate mode the terminal count freezes the whole chain.
    assign w_cnt = en & ~load & ~(cop & (WRAP == 0));

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
        logic w_step;

        assign w_lo_max[gi+1]  = w_lo_max[gi]  & w_at_max[gi];
        assign w_lo_zero[gi+1] = w_lo_zero[gi] & w_at_zero[gi];
        assign w_step = w_cnt & ((w_dir == DIR_UP) ? w_lo_max[gi] : w_lo_zero[gi]);

        mod_digit_cell #(
            .MOD (MOD)
        ) u_cell (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_load     (load),
            .i_step     (w_step),
            .i_dir      (w_dir),
            .i_load_nib (load_val[DIGIT_W*gi +: DIGIT_W]),
            .o_value    (num[DIGIT_W*gi +: DIGIT_W]),
            .o_at_max   (w_at_max[gi]),
            .o_at_zero  (w_at_zero[gi])
        );
    end

    assign cop = (w_dir == DIR_UP) ? w_lo_max[DIGITS] : w_lo_zero[DIGITS];

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_ovf <= 1'b0;
        else
            r_ovf <= en & ~load & cop;
    end

    assign ovf = r_ovf;

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: four parameterisations driven in lock-step,
// checked against an integer-valued reference model, a directed vector table
// and hand-written corner-case sequences.
module tb_mod_updown_counter;

    typedef struct {
        bit          r;
        bit          e;
        bit          s;
        bit          l;
        logic [31:0] lv;
        logic [7:0]  num;
        bit          cop;
        bit          ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        en = 1'b0;
    logic        sta = 1'b0;
    logic        load = 1'b0;
    logic [31:0] lv = '0;

    logic [7:0]  num0, num1;
    logic [3:0]  num2;
    logic [11:0] num3;
    logic [3:0]  cop_v, ovf_v;

    always #5 clk = ~clk;

    mod_updown_counter #(.DIGITS(2), .MOD(10), .WRAP(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .sta(sta), .load(load),
        .load_val(lv[7:0]), .num(num0), .cop(cop_v[0]), .ovf(ovf_v[0]));
    mod_updown_counter #(.DIGITS(2), .MOD(10), .WRAP(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .sta(sta), .load(load),
        .load_val(lv[7:0]), .num(num1), .cop(cop_v[1]), .ovf(ovf_v[1]));
    mod_updown_counter #(.DIGITS(1), .MOD(16), .WRAP(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .sta(sta), .load(load),
        .load_val(lv[3:0]), .num(num2), .cop(cop_v[2]), .ovf(ovf_v[2]));
    mod_updown_counter #(.DIGITS(3), .MOD(2), .WRAP(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .sta(sta), .load(load),
        .load_val(lv[11:0]), .num(num3), .cop(cop_v[3]), .ovf(ovf_v[3]));

    int p_mod [4] = '{10, 10, 16, 2};
    int p_dig [4] = '{2, 2, 1, 3};
    int p_wrap[4] = '{1, 0, 1, 1};

    int  m_val[4];
    bit  m_ovf[4];
    bit  model_valid = 1'b0;
    int  n_cmp = 0;
    int  n_bad = 0;
    vec_t tbl[20];

    function automatic int total(int k);
        int r = 1;
        for (int d = 0; d < p_dig[k]; d++) r = r * p_mod[k];
        return r;
    endfunction

    function automatic logic [31:0] pack(int k, int v);
        logic [31:0] p = '0;
        int x = v;
        for (int d = 0; d < p_dig[k]; d++) begin
            p[4*d +: 4] = 4'(x % p_mod[k]);
            x = x / p_mod[k];
        end
        return p;
    endfunction

    function automatic int load_int(int k, logic [31:0] v);
        int r = 0;
        int w = 1;
        int nib;
        for (int d = 0; d < p_dig[k]; d++) begin
            nib = int'(v[4*d +: 4]);
            if (nib >= p_mod[k]) nib = p_mod[k] - 1;
            r = r + nib * w;
            w = w * p_mod[k];
        end
        return r;
    endfunction

    function automatic bit model_cop(int k, bit s);
        return s ? (m_val[k] == 0) : (m_val[k] == total(k) - 1);
    endfunction

    function automatic logic [31:0] get_num(int k);
        case (k)
            0:       return {24'd0, num0};
            1:       return {24'd0, num1};
            2:       return {28'd0, num2};
            default: return {20'd0, num3};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input bit s, input bit l, input logic [31:0] v);
        bit term;
        rst_n = r; en = e; sta = s; load = l; lv = v;
        #2;
        if (model_valid)
            for (int k = 0; k < 4; k++)
                chk($sformatf("cop_pre%0d", k), {31'd0, cop_v[k]}, {31'd0, model_cop(k, s)});
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            term = model_cop(k, s);
            if (!r) begin
                m_val[k] = 0; m_ovf[k] = 0;
            end else if (l) begin
                m_val[k] = load_int(k, v); m_ovf[k] = 0;
            end else if (e) begin
                m_ovf[k] = term;
                if (term) begin
                    if (p_wrap[k] != 0) m_val[k] = s ? total(k) - 1 : 0;
                end else begin
                    m_val[k] = s ? m_val[k] - 1 : m_val[k] + 1;
                end
            end else begin
                m_ovf[k] = 0;
            end
        end
        if (!r) model_valid = 1'b1;
        #1;
        if (model_valid)
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("num%0d", k), get_num(k), pack(k, m_val[k]));
                chk($sformatf("ovf%0d", k), {31'd0, ovf_v[k]}, {31'd0, m_ovf[k]});
            end
    endtask

    initial begin
        logic [31:0] rv;
        logic [2:0]  bits;
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h57,  8'h00, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h50,  8'h50, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   8'h49, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   8'h48, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'hFC,  8'h99, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,   8'h00, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h09,  8'h09, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   8'h10, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   8'h09, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,   8'h10, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h57,  8'h57, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h33,  8'h00, 1'b0, 1'b0};
        for (int i = 13; i < 18; i++)
            tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 1'b0};
        tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,   8'h99, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,   8'h99, 1'b0, 1'b0};

        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            cycle(tbl[i].r, tbl[i].e, tbl[i].s, tbl[i].l, tbl[i].lv);
            chk($sformatf("tbl%0d_num", i), {24'd0, num0},       {24'd0, tbl[i].num});
            chk($sformatf("tbl%0d_cop", i), {31'd0, cop_v[0]},   {31'd0, tbl[i].cop});
            chk($sformatf("tbl%0d_ovf", i), {31'd0, ovf_v[0]},   {31'd0, tbl[i].ovf});
        end

        // Full decade count with wrap
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            if (i == 98) begin
                chk("up99_num", {24'd0, num0}, 32'h99);
                chk("up99_cop", {31'd0, cop_v[0]}, 32'd1);
            end
            if (i == 99) begin
                chk("wrap_num", {24'd0, num0}, 32'h00);
                chk("wrap_ovf", {31'd0, ovf_v[0]}, 32'd1);
            end
        end

        // Saturate at 99, then reverse
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h999);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            chk("sat_num", {24'd0, num1}, 32'h99);
            chk("sat_ovf", {31'd0, ovf_v[1]}, 32'd1);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("sat_rev_num", {24'd0, num1}, 32'h98);
        chk("sat_rev_ovf", {31'd0, ovf_v[1]}, 32'd0);

        // Single hex digit underflow, then three-digit binary sequence
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("hex_down_num", {28'd0, num2}, 32'hF);
        chk("hex_down_ovf", {31'd0, ovf_v[2]}, 32'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
            bits = 3'(i % 8);
            chk($sformatf("bin_%0d", i), {20'd0, num3},
                {20'd0, 3'd0, bits[2], 3'd0, bits[1], 3'd0, bits[0]});
            if (i == 8) chk("bin_wrap_ovf", {31'd0, ovf_v[3]}, 32'd1);
        end

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 3))
                0:       rv = 32'h0;
                1:       rv = 32'hFFFF_FFFF;
                default: rv = $urandom;
            endcase
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0, rv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 Parameter DIGITS, default 2, number of cascaded digits (1..8).
REQ-002 Parameter MOD, default 10, per-digit modulus (2..16); each digit counts 0..MOD-1.
REQ-003 Parameter WRAP, default 1: 1 wraps at terminal count, 0 saturates at terminal count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 en  input  1  count enable; 0 holds value.
REQ-007 sta  input  1  direction: 0 = up, 1 = down.
REQ-008 load  input  1  synchronous parallel load strobe.
REQ-009 load_val  input  4*DIGITS  load value, digit i in bits [4i+3:4i].
REQ-010 num  output  4*DIGITS  count value, digit i in bits [4i+3:4i], digit 0 least significant.
REQ-011 cop  output  1  combinational terminal-count flag.
REQ-012 ovf  output  1  registered one-cycle wrap/saturate-event pulse.

Function
REQ-013 Per-edge priority SHALL be: reset > load > count (en=1) > hold.
REQ-014 On load, each digit SHALL take its load_val nibble, clamped to MOD-1 if the nibble >= MOD; ovf SHALL be 0 that cycle.
REQ-015 With en=1 and sta=0, digit 0 SHALL increment; digit i>0 SHALL increment only when all lower digits equal MOD-1; a digit at MOD-1 that increments SHALL become 0.
REQ-016 With en=1 and sta=1, digit 0 SHALL decrement; digit i>0 SHALL decrement only when all lower digits equal 0; a digit at 0 that decrements SHALL become MOD-1.
REQ-017 cop SHALL be 1 when (sta=0 and every digit = MOD-1) or (sta=1 and every digit = 0), regardless of en, else 0.
REQ-018 When en=1, load=0 and cop=1: WRAP=1 SHALL wrap (up: all 0; down: all MOD-1); WRAP=0 SHALL hold the value.
REQ-019 ovf SHALL be 1 for exactly the cycle after any edge with en=1, load=0, rst_n=1, cop=1 (both WRAP modes), else 0.
REQ-020 Direction change SHALL take effect on the next edge with no lost or extra count; cop SHALL follow sta combinationally in the same cycle.
REQ-021 Count latency SHALL be one cycle: num reflects a step on the edge where en=1 is sampled.
REQ-022 Digit arithmetic SHALL be modulo-MOD; no digit SHALL ever hold a value >= MOD outside reset.

Reset
REQ-023 With rst_n=0 at a rising edge, num SHALL become all zero and ovf 0, overriding load and en.
REQ-024 Reset asserted mid-count SHALL take effect on the next edge only; between edges num holds.
REQ-025 After reset release, cop SHALL equal 1 if sta=1 (value 0, down) and 0 if sta=0 (for MOD>1 or DIGITS>=1).

Structure
REQ-026 Shared package counter_pkg SHALL hold the digit width constant (4), parameter legality limits, and direction encodings UP=0/DOWN=1.
REQ-027 A sub-module mod_digit_cell (one digit: value register, modulo step, clamp-on-load, at_max/at_zero outputs) SHALL be instantiated DIGITS times via generate.
REQ-028 Cascade enables SHALL be computed combinationally from lower-digit at_max/at_zero; no registered carry chain.
REQ-029 Elaboration SHALL fail on MOD outside 2..16 or DIGITS outside 1..8.

Verification (DIGITS=2, MOD=10 unless stated)
REQ-030 Reset, then en=1 sta=0 for 100 cycles -> num steps 00..99, cop=1 at 99, num=00 and ovf=1 for one cycle after the wrap.
REQ-031 Load 0x5_0, sta=1, en=1 -> 49, 48, ...; load 0xF_C -> num=0x99 (both digits clamped).
REQ-032 WRAP=0, at 99, sta=0 en=1 for 3 cycles -> num stays 99, ovf=1 each of those cycles; switch sta=1 -> cop=0 immediately, next edge 98.
REQ-033 At 09, toggle sta each cycle with en=1 -> 10, 09, 10; cop=0 throughout; no ovf.
REQ-034 rst_n=0 together with load=1 and en=1 at value 57 -> num=00, ovf=0 next cycle; en=0 for 5 cycles -> num holds.
REQ-035 MOD=16, DIGITS=1, sta=1 from 0 -> num=F, ovf=1; MOD=2 DIGITS=3 up from 000 -> binary-equivalent sequence 000..111, wrap to 000.
